elink_tx_scheduler: RTL

Round-robin scheduler that shares one e-link TX FIFO write port (the FIFO-to-e-link serializer input) between N CAN-channel frame sources in the MOPS-Hub. It grants one requester at a time and captures its fixed-length frame. It then writes the frame as SOP, FRAME_BYTES data words and EOP into the FIFO, obeying the FIFO prog-full backpressure. It also sequences FIFO flushes requested by slow control.

---
 rtl/elink_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/elink_tx_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/elink_pkg.sv
// Shared e-link TX definitions: FIFO word codes, scheduler state encoding and word layout.
// Pure definitions, no logic, so there is no latency and no backpressure behaviour.
package elink_pkg;

    localparam int WORD_W = 10;

    localparam logic [1:0] CODE_DATA  = 2'b00;
    localparam logic [1:0] CODE_EOP   = 2'b01;
    localparam logic [1:0] CODE_SOP   = 2'b10;
    localparam logic [1:0] CODE_COMMA = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SOP   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP   = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] dat;
    } efifo_word_t;

    function automatic efifo_word_t mk_word(input logic [1:0] code, input logic [7:0] dat);
        efifo_word_t w;
        w.code = code;
        w.dat  = dat;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester after the last-granted index; the pointer moves only on update.
// Grant is combinational from req and pointer; no backpressure, the caller decides when to accept.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

    logic [IW-1:0] last_q;
    logic [IW-1:0] pick;
    logic [IW-1:0] cidx;

    // Scan from farthest to nearest so the nearest active requester ends up selected.
    always_comb begin
        pick  = last_q;
        valid = 1'b0;
        cidx  = '0;
        for (int k = N; k >= 1; k--) begin
            cidx = IW'((int'(last_q) + k) % N);
            if (req[cidx]) begin
                pick  = cidx;
                valid = 1'b1;
            end
        end
        grant = valid ? (N'(1) << pick) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PTR_RST;
        end else if (update && valid) begin
            last_q <= pick;
        end
    end

endmodule

// File: rtl/elink_tx_scheduler.sv
// Shares one e-link TX FIFO write port between N_REQ frame sources, writing SOP/DATA/EOP; also sequences flushes.
// Grant->ack 1 clk, first word 2 clks after req; prog-full stalls the word stream without drop or repeat.
module elink_tx_scheduler
    import elink_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int FRAME_BYTES  = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                           clk_40,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*FRAME_BYTES*8-1:0] frame_in,
    output logic [N_REQ-1:0]               ack,
    input  logic                           flush_req,
    input  logic                           efifoPfull,
    output logic [WORD_W-1:0]              efifoDin,
    output logic                           efifoWe,
    output logic                           fifo_flush,
    output logic                           busy,
    output logic [15:0]                    frame_cnt
);

    localparam int FRAME_W = FRAME_BYTES * 8;
    localparam int IDX_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int FCNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_BYTE  = IDX_W'(FRAME_BYTES - 1);
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);

    logic [2:0]         state;
    logic [2:0]         state_n;
    logic [N_REQ-1:0]   arb_gnt;
    logic               arb_vld;
    logic [FRAME_W-1:0] frame_sel;
    logic [FRAME_W-1:0] shift_q;
    logic [IDX_W-1:0]   byte_idx;
    logic [FCNT_W-1:0]  flush_cnt;
    logic               do_grant;
    logic               do_write;
    logic [1:0]         wr_code;
    logic               in_frame;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk    (clk_40),
        .rst_n  (rst),
        .req    (req),
        .update (do_grant),
        .grant  (arb_gnt),
        .valid  (arb_vld)
    );

    always_comb begin
        frame_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                frame_sel = frame_sel | frame_in[i*FRAME_W +: FRAME_W];
            end
        end
    end

    assign in_frame = (state == ST_SOP) || (state == ST_DATA) || (state == ST_EOP);

    always_comb begin
        state_n  = state;
        do_grant = 1'b0;
        do_write = 1'b0;
        wr_code  = CODE_DATA;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_n = ST_FLUSH;
                end else if (arb_vld) begin
                    do_grant = 1'b1;
                    state_n  = ST_SOP;
                end
            end
            ST_SOP: begin
                if (!efifoPfull) begin
                    do_write = 1'b1;
                    wr_code  = CODE_SOP;
                    state_n  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!efifoPfull) begin
                    do_write = 1'b1;
                    wr_code  = CODE_DATA;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = ST_EOP;
                    end
                end
            end
            ST_EOP: begin
                if (!efifoPfull) begin
                    do_write = 1'b1;
                    wr_code  = CODE_EOP;
                    state_n  = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // A flush mid-frame wins over the pending write; the frame is dropped without EOP.
        if (in_frame && flush_req) begin
            do_write = 1'b0;
            state_n  = ST_FLUSH;
        end
    end

    always_ff @(posedge clk_40 or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ack        <= '0;
            efifoDin   <= '0;
            efifoWe    <= 1'b0;
            fifo_flush <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= 16'd0;
            shift_q    <= '0;
            byte_idx   <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != ST_IDLE);
            fifo_flush <= (state_n == ST_FLUSH);
            ack        <= do_grant ? arb_gnt : '0;
            efifoWe    <= do_write;

            if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt + FCNT_W'(1);
            end else begin
                flush_cnt <= '0;
            end

            if (do_grant) begin
                shift_q <= frame_sel;
            end

            if (do_write) begin
                efifoDin <= mk_word(wr_code, (wr_code == CODE_DATA) ? shift_q[7:0] : 8'h00);
                if (wr_code == CODE_SOP) begin
                    byte_idx <= '0;
                end
                if (wr_code == CODE_DATA) begin
                    byte_idx <= byte_idx + IDX_W'(1);
                    shift_q  <= shift_q >> 8;
                end
                if (wr_code == CODE_EOP) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule
